// File: rtl/write_record_tracker_pkg.sv
// Shared types and constants for the write-hazard record tracker.
package write_record_tracker_pkg;

  localparam int MASK_W     = 512;
  localparam int OFFSET_W   = 6;
  localparam int GROUP_REGS = 8;
  localparam int REG_W      = 5;
  localparam int INDEX_W    = 3;

  typedef struct packed {
    logic               vd_valid;
    logic [REG_W-1:0]   vd_bits;
    logic               vs1_valid;
    logic [REG_W-1:0]   vs1_bits;
    logic [REG_W-1:0]   vs2;
    logic [INDEX_W-1:0] inst_index;
    logic               gather;
    logic               gather16;
    logic               only_read;
  } record_fields_t;

endpackage

// File: rtl/write_record_tracker_record_slot.sv
// One in-flight instruction record: captured issue fields plus the
// per-element written mask. Clear (completion) outranks a same-cycle set.
module record_slot
  import write_record_tracker_pkg::*;
#(
  parameter int MASK_W = write_record_tracker_pkg::MASK_W,
  parameter int BIT_W  = $clog2(MASK_W)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic                 clear,
  input  logic                 set_en,
  input  logic [BIT_W-1:0]     set_index,
  input  record_fields_t       fields_in,
  output logic                 valid,
  output record_fields_t       fields,
  output logic [MASK_W-1:0]    mask,
  output logic                 all_written
);

  // Slot state: allocate, complete, or mark one element as written.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= 1'b0;
      fields <= '0;
      mask   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      mask  <= '0;
    end else if (alloc) begin
      valid  <= 1'b1;
      fields <= fields_in;
      mask   <= '0;
    end else if (set_en) begin
      mask[set_index] <= 1'b1;
    end
  end

  assign all_written = &mask;

endmodule

// File: rtl/write_record_tracker.sv
// Producer side of the write-hazard record interface: allocates records on
// issue, accumulates element write-backs, frees records on completion.
module write_record_tracker
  import write_record_tracker_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int MASK_W   = write_record_tracker_pkg::MASK_W,
  parameter int OFFSET_W = write_record_tracker_pkg::OFFSET_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic                      issue_bits_vd_valid,
  input  logic [4:0]                issue_bits_vd_bits,
  input  logic                      issue_bits_vs1_valid,
  input  logic [4:0]                issue_bits_vs1_bits,
  input  logic [4:0]                issue_bits_vs2,
  input  logic [2:0]                issue_bits_instIndex,
  input  logic                      issue_bits_gather,
  input  logic                      issue_bits_gather16,
  input  logic                      issue_bits_onlyRead,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_vd,
  input  logic [OFFSET_W-1:0]       wb_offset,
  input  logic [2:0]                wb_instIndex,
  input  logic                      done_valid,
  input  logic [2:0]                done_instIndex,
  output logic [SLOTS-1:0]          record_valid,
  output logic [SLOTS-1:0]          record_bits_vd_valid,
  output logic [SLOTS*5-1:0]        record_bits_vd_bits,
  output logic [SLOTS-1:0]          record_bits_vs1_valid,
  output logic [SLOTS*5-1:0]        record_bits_vs1_bits,
  output logic [SLOTS*5-1:0]        record_bits_vs2,
  output logic [SLOTS*3-1:0]        record_bits_instIndex,
  output logic [SLOTS-1:0]          record_bits_gather,
  output logic [SLOTS-1:0]          record_bits_gather16,
  output logic [SLOTS-1:0]          record_bits_onlyRead,
  output logic [SLOTS*MASK_W-1:0]   record_bits_elementMask,
  output logic [SLOTS-1:0]          record_allWritten,
  output logic                      dup_error
);

  localparam int BIT_W = $clog2(MASK_W);

  record_fields_t          issue_fields;
  record_fields_t          slot_fields [SLOTS];
  logic [SLOTS-1:0]        alloc_onehot;
  logic [SLOTS-1:0]        wb_hit;
  logic [SLOTS-1:0]        done_hit;
  logic [SLOTS-1:0]        live_hit;
  logic [BIT_W-1:0]        set_index [SLOTS];
  logic                    issue_fire;

  assign issue_fields = '{
    vd_valid:   issue_bits_vd_valid,
    vd_bits:    issue_bits_vd_bits,
    vs1_valid:  issue_bits_vs1_valid,
    vs1_bits:   issue_bits_vs1_bits,
    vs2:        issue_bits_vs2,
    inst_index: issue_bits_instIndex,
    gather:     issue_bits_gather,
    gather16:   issue_bits_gather16,
    only_read:  issue_bits_onlyRead
  };

  // Readiness depends only on registered valids, so a slot freed this
  // cycle cannot be reused until the next one.
  assign issue_ready = ~&record_valid;
  assign issue_fire  = issue_valid & issue_ready;

  // Lowest-index free slot receives the new record.
  always_comb begin
    alloc_onehot = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!record_valid[i]) begin
        alloc_onehot    = '0;
        alloc_onehot[i] = issue_fire;
      end
    end
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic [4:0] rel;

    assign rel          = wb_vd - slot_fields[s].vd_bits;
    assign wb_hit[s]    = wb_valid & record_valid[s] & slot_fields[s].vd_valid &
                          (slot_fields[s].inst_index == wb_instIndex) &
                          (rel < 5'(GROUP_REGS));
    assign done_hit[s]  = done_valid & record_valid[s] &
                          (slot_fields[s].inst_index == done_instIndex);
    assign live_hit[s]  = record_valid[s] &
                          (slot_fields[s].inst_index == issue_bits_instIndex);
    assign set_index[s] = {rel[2:0], wb_offset};

    record_slot #(.MASK_W(MASK_W), .BIT_W(BIT_W)) u_slot (
      .clock       (clock),
      .reset       (reset),
      .alloc       (alloc_onehot[s]),
      .clear       (done_hit[s]),
      .set_en      (wb_hit[s]),
      .set_index   (set_index[s]),
      .fields_in   (issue_fields),
      .valid       (record_valid[s]),
      .fields      (slot_fields[s]),
      .mask        (record_bits_elementMask[s*MASK_W +: MASK_W]),
      .all_written (record_allWritten[s])
    );

    assign record_bits_vd_valid[s]       = slot_fields[s].vd_valid;
    assign record_bits_vd_bits[s*5 +: 5] = slot_fields[s].vd_bits;
    assign record_bits_vs1_valid[s]      = slot_fields[s].vs1_valid;
    assign record_bits_vs1_bits[s*5 +: 5] = slot_fields[s].vs1_bits;
    assign record_bits_vs2[s*5 +: 5]     = slot_fields[s].vs2;
    assign record_bits_instIndex[s*3 +: 3] = slot_fields[s].inst_index;
    assign record_bits_gather[s]         = slot_fields[s].gather;
    assign record_bits_gather16[s]       = slot_fields[s].gather16;
    assign record_bits_onlyRead[s]       = slot_fields[s].only_read;
  end

  // Sticky flag: an issue reused an instIndex that is still live.
  always_ff @(posedge clock) begin
    if (reset) begin
      dup_error <= 1'b0;
    end else if (issue_fire && (|live_hit)) begin
      dup_error <= 1'b1;
    end
  end

endmodule
